// File: rtl/spi_ram_pkg.sv
// spi_ram_pkg: definitions shared by the SPI-fronted RAM design.
//   state_e    - slave FSM states
//   CMD_*      - command codes carried in rx_data[9:8]
//   FRAME_BITS - bits per serial word (2 command + 8 payload)
//   DATA_BITS  - RAM word width
package spi_ram_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_e;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  localparam int FRAME_BITS = 10;
  localparam int DATA_BITS  = 8;

endpackage

// File: rtl/spi_ram_mem.sv
// spi_ram_mem: byte-wide single-port RAM with command decoder.
// On each rx_valid strobe rx_data[9:8] selects: set write address, write
// data, set read address, or read data (dout + one-cycle tx_valid).
// Optional macro SPI_RAM_ADDR_AUTOINC_EN: post-increment wr_addr after a
// data write and rd_addr after a data read, for sequential bursts.
// Ports:
//   clk       - system clock, rising edge
//   rst_n     - asynchronous reset, active HIGH (name kept from codebase)
//   rx_data   - command word {cmd[1:0], payload[7:0]}
//   rx_valid  - command strobe
//   dout      - read data
//   tx_valid  - one-cycle strobe, dout valid
module spi_ram_mem
  import spi_ram_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [FRAME_BITS-1:0] rx_data,
  input  logic                  rx_valid,
  output logic [DATA_BITS-1:0]  dout,
  output logic                  tx_valid
);

  logic [DATA_BITS-1:0] mem [MEM_DEPTH];
  logic [ADDR_SIZE-1:0] wr_addr;
  logic [ADDR_SIZE-1:0] rd_addr;
  logic [1:0]           cmd;

  assign cmd = rx_data[FRAME_BITS-1 -: 2];

  // NOTE: the array has no reset so it can map onto a real RAM macro;
  // contents survive rst_n.
  always_ff @(posedge clk) begin
    if (rx_valid && cmd == CMD_WR_DATA)
      mem[wr_addr] <= rx_data[DATA_BITS-1:0];
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      wr_addr  <= '0;
      rd_addr  <= '0;
      dout     <= '0;
      tx_valid <= 1'b0;
    end else begin
      tx_valid <= 1'b0;
      if (rx_valid) begin
        case (cmd)
          CMD_WR_ADDR: wr_addr <= rx_data[ADDR_SIZE-1:0];
          CMD_WR_DATA: begin
`ifdef SPI_RAM_ADDR_AUTOINC_EN
            wr_addr <= wr_addr + ADDR_SIZE'(1);
`else
            wr_addr <= wr_addr;
`endif
          end
          CMD_RD_ADDR: rd_addr <= rx_data[ADDR_SIZE-1:0];
          default: begin
            dout     <= mem[rd_addr];
            tx_valid <= 1'b1;
`ifdef SPI_RAM_ADDR_AUTOINC_EN
            rd_addr  <= rd_addr + ADDR_SIZE'(1);
`endif
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/spi_ram_slave.sv
// spi_slave_if: SPI slave shift engine.
// After SS_n falls the slave spends one cycle in IDLE and one in CHK_CMD,
// where MOSI selects a write or read path. It then shifts FRAME_BITS bits
// MSB-first into rx_data and pulses rx_valid for one cycle. When the RAM
// answers with tx_valid, dout is serialised MSB-first on miso.
// Ports:
//   clk       - system clock, rising edge
//   rst_n     - asynchronous reset, active HIGH (name kept from codebase)
//   ss_n      - slave select, active low; high aborts the frame
//   mosi      - serial data in
//   miso      - serial data out (registered)
//   rx_data   - received word {cmd[1:0], payload[7:0]}
//   rx_valid  - one-cycle strobe, rx_data complete
//   dout      - read data from RAM
//   tx_valid  - one-cycle strobe, dout valid
module spi_slave_if
  import spi_ram_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ss_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic [FRAME_BITS-1:0] rx_data,
  output logic                  rx_valid,
  input  logic [DATA_BITS-1:0]  dout,
  input  logic                  tx_valid
);

  localparam int CNT_W = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] FRAME_DONE = CNT_W'(FRAME_BITS);

  state_e               state;
  logic [CNT_W-1:0]     bit_cnt;
  logic                 rd_addr_flag;
  logic [DATA_BITS-2:0] tx_shift;
  logic [2:0]           tx_cnt;

  // NOTE: every register below is state, so all assignments are
  // non-blocking; blocking ones would let later statements see new values
  // within the same edge and break the shift/strobe timing.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rd_addr_flag <= 1'b0;
      miso         <= 1'b0;
      tx_shift     <= '0;
      tx_cnt       <= '0;
    end else begin
      rx_valid <= 1'b0;
      if (ss_n) begin
        // Abort: drop the partial word and any pending shift-out; the
        // read-address flag survives so a later READ_DATA frame still works.
        state    <= IDLE;
        bit_cnt  <= '0;
        miso     <= 1'b0;
        tx_shift <= '0;
        tx_cnt   <= '0;
      end else begin
        case (state)
          IDLE: state <= CHK_CMD;
          CHK_CMD: begin
            bit_cnt <= '0;
            if (!mosi)            state <= WRITE;
            else if (rd_addr_flag) state <= READ_DATA;
            else                  state <= READ_ADD;
          end
          WRITE, READ_ADD, READ_DATA: begin
            // Once FRAME_DONE is reached the slave ignores MOSI until SS_n rises.
            if (bit_cnt != FRAME_DONE) begin
              rx_data <= {rx_data[FRAME_BITS-2:0], mosi};
              bit_cnt <= bit_cnt + CNT_W'(1);
              if (bit_cnt == LAST_BIT) begin
                rx_valid <= 1'b1;
                if (state == READ_ADD)  rd_addr_flag <= 1'b1;
                if (state == READ_DATA) rd_addr_flag <= 1'b0;
              end
            end
          end
          default: state <= IDLE;
        endcase

        // MISO serializer: MSB goes out the cycle after tx_valid, the
        // remaining seven bits follow, then the line returns to 0.
        if (tx_valid) begin
          miso     <= dout[DATA_BITS-1];
          tx_shift <= dout[DATA_BITS-2:0];
          tx_cnt   <= 3'd7;
        end else if (tx_cnt != 3'd0) begin
          miso     <= tx_shift[DATA_BITS-2];
          tx_shift <= {tx_shift[DATA_BITS-3:0], 1'b0};
          tx_cnt   <= tx_cnt - 3'd1;
        end else begin
          miso <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/spi_ram_top.sv
// spi_ram_top: SPI slave front end driving a byte-wide RAM.
// The RAM instance is RAM_interface and holds array mem.
// Optional macro SPI_RAM_ADDR_AUTOINC_EN enables address auto-increment.
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - asynchronous reset, active HIGH (name kept from codebase)
//   SS_n   - SPI slave select, active low
//   MOSI   - serial data in, MSB first
//   MISO   - serial data out, MSB first, registered
module spi_ram_top
  import spi_ram_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic SS_n,
  input  logic MOSI,
  output logic MISO
);

  logic [FRAME_BITS-1:0] rx_data;
  logic                  rx_valid;
  logic [DATA_BITS-1:0]  dout;
  logic                  tx_valid;

  spi_slave_if u_slave (
    .clk      (clk),
    .rst_n    (rst_n),
    .ss_n     (SS_n),
    .mosi     (MOSI),
    .miso     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .dout     (dout),
    .tx_valid (tx_valid)
  );

  spi_ram_mem #(
    .MEM_DEPTH (MEM_DEPTH),
    .ADDR_SIZE (ADDR_SIZE)
  ) RAM_interface (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .dout     (dout),
    .tx_valid (tx_valid)
  );

endmodule

// File: tb/tb_spi_ram_top.sv
// tb_spi_ram_top: self-checking bench for spi_ram_top.
// Inputs change on the falling clock edge and outputs are sampled there too.
// A reference model (plain arrays and scalars) predicts RAM contents,
// addresses, the read-address flag and the MISO byte of every frame.
module tb_spi_ram_top;
  import spi_ram_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic ss_n;
  logic mosi;
  logic miso;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;

  // Reference model
  logic [7:0] model_mem   [256];
  bit         model_known [256];
  logic [7:0] model_wr;
  logic [7:0] model_rd;
  bit         model_flag;

  spi_ram_top DUT (
    .clk   (clk),
    .rst_n (rst_n),
    .SS_n  (ss_n),
    .MOSI  (mosi),
    .MISO  (miso)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (DUT.rx_valid === 1'b1) pulse_cnt++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_mem_all(input string tag);
    for (int a = 0; a < 256; a++)
      if (model_known[a]) check(tag, 32'(DUT.RAM_interface.mem[a]), 32'(model_mem[a]));
  endtask

  // One SPI frame: select, command bit, nbits payload bits. Complete frames
  // keep SS_n low long enough to capture the whole MISO byte and the idle bit.
  task automatic run_frame(input logic first, input logic [9:0] word, input int nbits);
    int         pulses0;
    logic [8:0] miso_bits;
    logic [1:0] cmd;
    logic [7:0] payload;
    logic [7:0] exp_byte;
    bit         exp_known;
    pulses0   = pulse_cnt;
    miso_bits = '0;
    cmd       = word[9:8];
    payload   = word[7:0];
    exp_byte  = 8'h00;
    exp_known = 1'b1;
    @(negedge clk); ss_n = 1'b0; mosi = 1'b0;
    @(negedge clk); mosi = first;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk); mosi = word[9-i];
    end
    if (nbits == 10) begin
      for (int j = 1; j <= 11; j++) begin
        @(negedge clk);
        mosi = 1'($urandom);
        if (j >= 3) miso_bits = {miso_bits[7:0], miso};
      end
    end
    @(negedge clk); ss_n = 1'b1;
    @(negedge clk);

    if (nbits == 10) begin
      if (first) model_flag = !model_flag;
      case (cmd)
        2'b00: model_wr = payload;
        2'b01: begin
          model_mem[model_wr]   = payload;
          model_known[model_wr] = 1'b1;
`ifdef SPI_RAM_ADDR_AUTOINC_EN
          model_wr = model_wr + 8'd1;
`endif
        end
        2'b10: model_rd = payload;
        default: begin
          exp_byte  = model_mem[model_rd];
          exp_known = model_known[model_rd];
`ifdef SPI_RAM_ADDR_AUTOINC_EN
          model_rd = model_rd + 8'd1;
`endif
        end
      endcase
    end

    check("rx_valid_pulses", 32'(pulse_cnt - pulses0), (nbits == 10) ? 32'd1 : 32'd0);
    check("rd_addr_flag", 32'(DUT.u_slave.rd_addr_flag), 32'(model_flag));
    check("wr_addr", 32'(DUT.RAM_interface.wr_addr), 32'(model_wr));
    check("rd_addr", 32'(DUT.RAM_interface.rd_addr), 32'(model_rd));
    if (nbits == 10 && exp_known)
      check("miso_stream", 32'(miso_bits), 32'({exp_byte, 1'b0}));
    check("idle_after_frame", 32'(DUT.u_slave.state), 32'(IDLE));
  endtask

  initial begin
    logic       r_first;
    logic [9:0] r_word;
    int         r_bits;
    for (int a = 0; a < 256; a++) begin
      model_known[a] = 1'b0;
      model_mem[a]   = 8'h00;
    end
    model_wr = 8'h00; model_rd = 8'h00; model_flag = 1'b0;

    // Reset values
    rst_n = 1'b1; ss_n = 1'b1; mosi = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_miso", 32'(miso), 32'd0);
    check("rst_state", 32'(DUT.u_slave.state), 32'(IDLE));
    check("rst_rx_valid", 32'(DUT.rx_valid), 32'd0);
    check("rst_rx_data", 32'(DUT.rx_data), 32'd0);
    check("rst_tx_valid", 32'(DUT.tx_valid), 32'd0);
    check("rst_dout", 32'(DUT.dout), 32'd0);
    check("rst_flag", 32'(DUT.u_slave.rd_addr_flag), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);

    // Preload neighbours through the serial port
    run_frame(1'b0, 10'b00_00000001, 10);
    run_frame(1'b0, 10'b01_00010001, 10);
    run_frame(1'b0, 10'b00_00000011, 10);
    run_frame(1'b0, 10'b01_00110011, 10);

    // Write address 0x02, then data 0x76
    run_frame(1'b0, 10'b00_00000010, 10);
    check("wr_addr_02", 32'(DUT.RAM_interface.wr_addr), 32'h02);
    run_frame(1'b0, 10'b01_01110110, 10);
    check("mem2", 32'(DUT.RAM_interface.mem[2]), 32'h76);
    check("mem1_kept", 32'(DUT.RAM_interface.mem[1]), 32'h11);
    check("mem3_kept", 32'(DUT.RAM_interface.mem[3]), 32'h33);

    // Read address 0x02, then read data: MISO carries 0x76
    run_frame(1'b1, 10'b10_00000010, 10);
    check("flag_set", 32'(DUT.u_slave.rd_addr_flag), 32'd1);
    run_frame(1'b1, 10'b11_00000000, 10);
    check("flag_clear", 32'(DUT.u_slave.rd_addr_flag), 32'd0);

    // Abort after 5 bits of a data write, then a full write of 0x5A
    run_frame(1'b0, 10'b00_00000100, 10);
    run_frame(1'b0, 10'b01_10100101, 5);
    check("abort_no_write_known", 32'(model_known[4]), 32'd0);
    run_frame(1'b0, 10'b01_01011010, 10);
    check("mem4_after_abort", 32'(DUT.RAM_interface.mem[4]), 32'h5A);

    // Reset asserted mid-frame for two cycles
    run_frame(1'b1, 10'b10_00000011, 10);
    run_frame(1'b0, 10'b00_00000001, 10);
    @(negedge clk); ss_n = 1'b0;
    @(negedge clk); mosi = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); mosi = (i == 1);
    end
    @(negedge clk); rst_n = 1'b1; ss_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("midrst_miso", 32'(miso), 32'd0);
    check("midrst_state", 32'(DUT.u_slave.state), 32'(IDLE));
    check("midrst_flag", 32'(DUT.u_slave.rd_addr_flag), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    model_wr = 8'h00; model_rd = 8'h00; model_flag = 1'b0;
    check("midrst_mem1", 32'(DUT.RAM_interface.mem[1]), 32'h11);
    check_mem_all("midrst_mem");

    // Sequential data writes to address 0x05
    run_frame(1'b0, 10'b00_00000101, 10);
    run_frame(1'b0, 10'b01_10101010, 10);
    run_frame(1'b0, 10'b01_10111011, 10);
`ifdef SPI_RAM_ADDR_AUTOINC_EN
    check("autoinc_mem5", 32'(DUT.RAM_interface.mem[5]), 32'hAA);
    check("autoinc_mem6", 32'(DUT.RAM_interface.mem[6]), 32'hBB);
`else
    check("noinc_mem5", 32'(DUT.RAM_interface.mem[5]), 32'hBB);
`endif

    // Randomized frames against the model
    for (int n = 0; n < 60; n++) begin
      r_first = 1'($urandom);
      r_word  = 10'($urandom);
      r_bits  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 9)) : 10;
      run_frame(r_first, r_word, r_bits);
    end
    check_mem_all("final_mem");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_ram_top.md
Name: spi_ram_top

Overview:
- SPI-slave-fronted single-port RAM: serial frames on MOSI carry address/data commands, and read data returns on MISO.
- Top level integrates a 10-bit SPI slave shift engine and a byte-wide RAM.
- The RAM instance is named RAM_interface and holds array mem, so benches can preload it hierarchically (DUT.RAM_interface.mem).

Parameters:
- MEM_DEPTH, 256: number of 8-bit RAM words.
- ADDR_SIZE, 8: address width; MEM_DEPTH = 2**ADDR_SIZE.

Ports:
- clk  input  1  single system clock, all logic on rising edge.
- rst_n  input  1  asynchronous, active-high reset (asserted when 1; name kept per codebase).
- SS_n  input  1  SPI slave select, active low; high ends/aborts a frame.
- MOSI  input  1  serial data in, sampled on clk rising edge, MSB first.
- MISO  output  1  serial data out, registered, MSB first.

Behaviour:
- Reset (async): FSM=IDLE, bit counter=0, rx_data=0, rx_valid=0, rd_addr_flag=0, wr_addr=0, rd_addr=0, dout=0, tx_valid=0, MISO=0. RAM contents are not cleared.
- FSM states are IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- IDLE: MISO=0. If SS_n=0, go to CHK_CMD.
- CHK_CMD: sample MOSI.
  - MOSI=0: go to WRITE.
  - MOSI=1 and rd_addr_flag=0: go to READ_ADD.
  - MOSI=1 and rd_addr_flag=1: go to READ_DATA.
- WRITE, READ_ADD, READ_DATA: shift 10 MOSI bits MSB-first into rx_data[9:0].
  - After the 10th bit, rx_valid is high for exactly one cycle with the full word, then the slave ignores further MOSI.
  - READ_ADD sets rd_addr_flag once its word completes.
  - READ_DATA clears rd_addr_flag.
- RAM decodes rx_data[9:8] on the clock edge where rx_valid=1:
  - 00: wr_addr <= rx_data[7:0].
  - 01: mem[wr_addr] <= rx_data[7:0].
  - 10: rd_addr <= rx_data[7:0].
  - 11: dout <= mem[rd_addr]; tx_valid=1 for one cycle.
- Read latency: rx_valid high in cycle k → tx_valid/dout valid in cycle k+1 → MISO=dout[7] in cycle k+2 … dout[0] in cycle k+9, then MISO=0.
- The FSM remains in READ_DATA until SS_n rises.
- SS_n=1 in any state → IDLE next edge; counter cleared, MISO=0, pending shift-out discarded. rd_addr_flag is preserved.
- Partial frames (<10 bits) produce no rx_valid and change no RAM state.
- Address width is truncated to ADDR_SIZE; no wrap checks needed at 256 words.
- Write and read addresses are independent registers.

Optional Feature:
- Macro: SPI_RAM_ADDR_AUTOINC_EN.
- Defined: wr_addr increments by 1 (mod MEM_DEPTH) after every 01 data write, and rd_addr increments by 1 after every 11 data read, allowing sequential bursts without resending the address.
- Undefined: addresses change only on 00/10 commands.

Decomposition:
- Package spi_ram_pkg holds:
  - state enum {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA};
  - command localparams CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11;
  - FRAME_BITS=10, DATA_BITS=8.
- Sub-modules:
  - spi_slave_if (FSM, shift registers, MISO serializer);
  - RAM storage as instance RAM_interface (array mem), connected via rx_data/rx_valid/dout/tx_valid.

Test Plan:
- Reset: rst_n=1 for 2 cycles mid-frame → MISO=0, FSM IDLE, no RAM write; preloaded mem unchanged.
- Write address: SS_n=0, MOSI 0 then 00_00000010, SS_n=1 → wr_addr=0x02, one rx_valid pulse, no mem change.
- Write data: frame 0 + 01_01110110 → mem[2]=0x76; mem[1], mem[3] unchanged.
- Read address, then read data:
  - frame 1 + 10_00000010 → rd_addr=0x02, rd_addr_flag=1;
  - frame 1 + 11_00000000 → MISO shifts 0,1,1,1,0,1,1,0 in cycles k+2..k+9; rd_addr_flag=0.
- Abort: SS_n rises after 5 bits of a 01 frame → no write; next full frame decodes correctly from bit 0.
- With SPI_RAM_ADDR_AUTOINC_EN: write addr 0x05, data 0xAA, data 0xBB → mem[5]=0xAA, mem[6]=0xBB.
